pipe_stage_mem_dmem: RTL and testbench

//  MEM stage data-memory unit. Sits between the EX/MEM register and the MEM/WB register.

---
 rtl/pipe_stage_mem_dmem_if.sv | 28 ++
 rtl/pipe_stage_mem_dmem.sv | 138 +++++++++++++
 tb/tb_pipe_stage_mem_dmem.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_mem_dmem_if.sv
// EX/MEM -> MEM stage request bus and MEM -> MEM/WB result bus, with the upstream stall.
interface pipe_stage_mem_dmem_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned RD_W   = 2
);
  logic              in_valid;
  logic              in_mem_read;
  logic              in_mem_write;
  logic [RD_W-1:0]   in_rd;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [DATA_W-1:0] in_alu;
  logic              stall;
  logic              out_valid;
  logic [RD_W-1:0]   out_rd;
  logic [DATA_W-1:0] out_mem;

  modport master (
    output in_valid, in_mem_read, in_mem_write, in_rd, in_addr, in_wdata, in_alu,
    input  stall, out_valid, out_rd, out_mem
  );

  modport slave (
    input  in_valid, in_mem_read, in_mem_write, in_rd, in_addr, in_wdata, in_alu,
    output stall, out_valid, out_rd, out_mem
  );
endinterface

// File: rtl/pipe_stage_mem_dmem.sv
// MEM stage data-memory unit: multi-cycle loads/stores on a private RAM, ALU pass-through.
// Optional feature: define PIPE_STAGE_MEM_ZERO_INIT_EN to clear the RAM on reset.
module pipe_stage_mem_dmem #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned RD_W    = 2,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_stage_mem_dmem_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              out_valid_q, out_valid_d;
  logic [RD_W-1:0]   out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_mem_q, out_mem_d;
  logic              stall_c;
  logic              ram_we;
  logic              mem_op;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] ram [DEPTH];

  assign mem_op    = bus.in_mem_read | bus.in_mem_write;
  assign ram_rdata = ram[addr_q];

  // Next-state, latch and result selection; a read+write request is handled as a store.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_mem_d   = out_mem_q;
    stall_c     = 1'b0;
    ram_we      = 1'b0;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
          if (mem_op) begin
            stall_c = 1'b1;
            store_d = bus.in_mem_write;
            rd_d    = bus.in_rd;
            addr_d  = bus.in_addr;
            wdata_d = bus.in_wdata;
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end else begin
            out_valid_d = 1'b1;
            out_rd_d    = bus.in_rd;
            out_mem_d   = bus.in_alu;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          if (store_q) begin
            ram_we      = 1'b1;
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            out_rd_d    = rd_q;
            out_mem_d   = ram_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset masks stall so upstream is never frozen while the unit is held in reset.
  assign bus.stall     = reset & stall_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_mem   = out_mem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      rd_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_mem_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_mem_q   <= out_mem_d;
    end
  end

  // A store only commits in its final BUSY cycle, so reset before then discards it.
`ifdef PIPE_STAGE_MEM_ZERO_INIT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= '0;
    end else if (ram_we) begin
      ram[addr_q] <= wdata_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (ram_we) ram[addr_q] <= wdata_q;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_mem_dmem.sv
// Bench for pipe_stage_mem_dmem: directed scenarios plus random ops against a transaction-level model.
module tb_pipe_stage_mem_dmem;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned RD_W   = 2;
  localparam int unsigned LAT    = 2;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BOTH  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_stage_mem_dmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W)) bus0 ();
  pipe_stage_mem_dmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W)) bus1 ();

  pipe_stage_mem_dmem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W), .MEM_LAT(LAT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  pipe_stage_mem_dmem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W), .MEM_LAT(1)) u_dut_lat1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Reference model: RAM contents, which words are defined, last written-back result.
  logic [DATA_W-1:0] mem_m [16];
  bit                known [16];
  logic [RD_W-1:0]   last_rd;
  logic [DATA_W-1:0] last_mem;
  bit                last_mem_known;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_rd        = '0;
    last_mem       = '0;
    last_mem_known = 1'b1;
`ifdef PIPE_STAGE_MEM_ZERO_INIT_EN
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = '0;
      known[i] = 1'b1;
    end
`endif
  endtask

  task automatic check_outputs(input string tag, input logic exp_valid);
    check({tag, "_valid"}, 32'(bus0.out_valid), 32'(exp_valid));
    check({tag, "_rd"}, 32'(bus0.out_rd), 32'(last_rd));
    if (last_mem_known) check({tag, "_mem"}, 32'(bus0.out_mem), 32'(last_mem));
  endtask

  // Issue one op and hold it while stalled; checks stall count, latency and result.
  task automatic do_op(input int kind, input logic [ADDR_W-1:0] addr, input logic [RD_W-1:0] rd,
                       input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] alu);
    int   stalls;
    int   edges;
    logic st;
    bit   mem_op;
    logic exp_valid;
    mem_op = (kind != K_ALU);
    @(negedge clk);
    bus0.in_valid     = 1'b1;
    bus0.in_mem_read  = (kind == K_LOAD) || (kind == K_BOTH);
    bus0.in_mem_write = (kind == K_STORE) || (kind == K_BOTH);
    bus0.in_rd        = rd;
    bus0.in_addr      = addr;
    bus0.in_wdata     = wd;
    bus0.in_alu       = alu;
    #1;
    stalls = 0;
    edges  = 0;
    while (edges < 32) begin
      st = bus0.stall;
      if (st === 1'b1) stalls++;
      @(posedge clk);
      #1;
      edges++;
      if (st !== 1'b1) break;
      check("inflight_valid", 32'(bus0.out_valid), 32'(0));
    end
    check("stall_cycles", 32'(stalls), mem_op ? 32'(LAT) : 32'(0));
    check("latency", 32'(edges), mem_op ? 32'(LAT + 1) : 32'(1));
    if (kind == K_ALU) begin
      exp_valid = 1'b1; last_rd = rd; last_mem = alu; last_mem_known = 1'b1;
    end else if (kind == K_LOAD) begin
      exp_valid = 1'b1; last_rd = rd;
      last_mem = mem_m[addr]; last_mem_known = known[addr];
    end else begin
      exp_valid = 1'b0; mem_m[addr] = wd; known[addr] = 1'b1;
    end
    check_outputs("result", exp_valid);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus0.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("idle", 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = '0;
      known[i] = 1'b0;
    end
    reset = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_mem_read = 1'b0; bus0.in_mem_write = 1'b0;
    bus0.in_rd = '0; bus0.in_addr = '0; bus0.in_wdata = '0; bus0.in_alu = '0;
    bus1.in_valid = 1'b0; bus1.in_mem_read = 1'b0; bus1.in_mem_write = 1'b0;
    bus1.in_rd = '0; bus1.in_addr = '0; bus1.in_wdata = '0; bus1.in_alu = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(bus0.stall), 32'(0));
    check_outputs("rst", 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // ALU pass-through
    do_op(K_ALU, 4'd0, 2'd2, 8'h00, 8'h5A);
    // store/load at the top address
    do_op(K_STORE, 4'd15, 2'd0, 8'hC3, 8'h00);
    do_op(K_LOAD, 4'd15, 2'd1, 8'h00, 8'h00);
    // back-to-back loads then ALU
    do_op(K_STORE, 4'd0, 2'd0, 8'h3C, 8'h00);
    do_op(K_LOAD, 4'd0, 2'd3, 8'h00, 8'h00);
    do_op(K_LOAD, 4'd15, 2'd2, 8'h00, 8'h00);
    do_op(K_ALU, 4'd0, 2'd1, 8'h00, 8'h11);
    idle_cycle();
    // read+write together behaves as a store
    do_op(K_BOTH, 4'd5, 2'd0, 8'hA5, 8'h00);
    do_op(K_LOAD, 4'd5, 2'd3, 8'h00, 8'h00);

    // reset while a store is in flight: store must be dropped
    do_op(K_STORE, 4'd3, 2'd0, 8'h12, 8'h00);
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.in_mem_read = 1'b0; bus0.in_mem_write = 1'b1;
    bus0.in_addr = 4'd3; bus0.in_wdata = 8'h77;
    #1;
    check("abort_accept_stall", 32'(bus0.stall), 32'(1));
    @(posedge clk);
    #1;
    check("abort_busy_stall", 32'(bus0.stall), 32'(1));
    reset = 1'b0;
    model_reset();
    #1;
    check("abort_rst_stall", 32'(bus0.stall), 32'(0));
    check_outputs("abort_rst", 1'b0);
    @(posedge clk);
    #1;
    check("abort_rst_stall2", 32'(bus0.stall), 32'(0));
    @(negedge clk);
    bus0.in_valid = 1'b0;
    reset = 1'b1;
    do_op(K_LOAD, 4'd3, 2'd1, 8'h00, 8'h00);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      else do_op(int'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 15)),
                 RD_W'($urandom_range(0, 3)), DATA_W'($urandom), DATA_W'($urandom));
    end
    idle_cycle();

    // single-cycle latency instance: load of a never-written address
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_mem_read = 1'b1; bus1.in_mem_write = 1'b0;
    bus1.in_rd = 2'd1; bus1.in_addr = 4'd9;
    #1;
    check("lat1_accept_stall", 32'(bus1.stall), 32'(1));
    @(posedge clk);
    #1;
    check("lat1_final_stall", 32'(bus1.stall), 32'(0));
    check("lat1_final_valid", 32'(bus1.out_valid), 32'(0));
    @(posedge clk);
    #1;
    check("lat1_valid", 32'(bus1.out_valid), 32'(1));
    check("lat1_rd", 32'(bus1.out_rd), 32'(1));
`ifdef PIPE_STAGE_MEM_ZERO_INIT_EN
    check("lat1_mem", 32'(bus1.out_mem), 32'(0));
`endif
    @(negedge clk);
    bus1.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("lat1_idle_valid", 32'(bus1.out_valid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
